trace_capture: RTL and testbench



---
 rtl/trace_pkg.sv | 13 +
 rtl/trace_ram.sv | 29 ++
 rtl/trace_capture.sv | 131 +++++++++++++
 tb/tb_trace_capture.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types and constants for the retired-instruction trace capture.
package trace_pkg;

  localparam int TRACE_DEPTH = 8;

  localparam logic [7:0] DROP_MAX = 8'hFF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
  } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// History storage: DEPTH x 64-bit register array, one synchronous write port
// and one asynchronous read port. Contents are not reset; the capture block
// masks the read data until at least one entry has been written.
module trace_ram
  import trace_pkg::*;
#(
  parameter int DEPTH = TRACE_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  trace_entry_t  wdata,
  input  logic [AW-1:0] raddr,
  output trace_entry_t  rdata
);

  trace_entry_t mem [DEPTH];

  // Store the retiring (pc, result) pair at the write pointer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/trace_capture.sv
// Captures (pc, result) on every accepted retire into a ring buffer and lets
// the operator browse recent history. The selected entry is presented on
// registered buses for the seven-segment path; depth, view position, wrap and
// dropped-capture status drive the board LEDs.
module trace_capture
  import trace_pkg::*;
#(
  parameter int DEPTH = TRACE_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          retire,
  input  logic [31:0]   pc_in,
  input  logic [31:0]   result_in,
  input  logic          freeze,
  input  logic          prev,
  input  logic          next,
  input  logic          sclr,
  output logic [31:0]   pc_out,
  output logic [31:0]   result_out,
  output logic [AW:0]   count,
  output logic [AW-1:0] offset,
  output logic          wrapped,
  output logic [7:0]    dropped
);

  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] wr_ptr_nxt;
  logic [AW:0]   count_nxt;
  logic [AW-1:0] offset_nxt;
  logic          wrapped_nxt;
  logic [7:0]    dropped_nxt;
  logic          capture;
  logic [AW-1:0] rd_idx;
  trace_entry_t  wr_entry;
  trace_entry_t  rd_entry;

  // A retire is only accepted while live; sclr suppresses the write as well.
  assign capture  = retire & ~freeze & ~sclr;
  assign wr_entry = '{pc: pc_in, result: result_in};

  // Newest entry sits just behind the write pointer; offset walks back from it.
  assign rd_idx = wr_ptr - PTR_ONE - offset;

  trace_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (capture),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_idx),
    .rdata (rd_entry)
  );

  // Next-state for pointers and status: sclr, then capture, then browse.
  always_comb begin
    wr_ptr_nxt  = wr_ptr;
    count_nxt   = count;
    offset_nxt  = offset;
    wrapped_nxt = wrapped;
    dropped_nxt = dropped;
    if (sclr) begin
      wr_ptr_nxt  = '0;
      count_nxt   = '0;
      offset_nxt  = '0;
      wrapped_nxt = 1'b0;
      dropped_nxt = '0;
    end else if (capture) begin
      wr_ptr_nxt = wr_ptr + PTR_ONE;
      offset_nxt = '0;
      if (count == DEPTH_CNT) begin
        wrapped_nxt = 1'b1;
      end else begin
        count_nxt = count + CNT_ONE;
      end
    end else begin
      if (retire && dropped != DROP_MAX) begin
        dropped_nxt = dropped + 8'd1;
      end
      if (prev && !next) begin
        if (({1'b0, offset} + CNT_ONE) < count) begin
          offset_nxt = offset + PTR_ONE;
        end
      end else if (next && !prev) begin
        if (offset != '0) begin
          offset_nxt = offset - PTR_ONE;
        end
      end
    end
  end

  // Pointer and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      count   <= '0;
      offset  <= '0;
      wrapped <= 1'b0;
      dropped <= '0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      count   <= count_nxt;
      offset  <= offset_nxt;
      wrapped <= wrapped_nxt;
      dropped <= dropped_nxt;
    end
  end

  // Display buses follow the registered view one cycle later; an empty
  // history shows zeros so uninitialised storage never reaches the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out     <= '0;
      result_out <= '0;
    end else if (sclr || count == '0) begin
      pc_out     <= '0;
      result_out <= '0;
    end else begin
      pc_out     <= rd_entry.pc;
      result_out <= rd_entry.result;
    end
  end

endmodule

// File: tb/tb_trace_capture.sv
// Scoreboard bench for trace_capture. A behavioural history model (newest at
// the queue front) predicts status after each edge and display data one edge
// later; predictions are queued when stimulus is driven and popped on output.
module tb_trace_capture;
  import trace_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          retire = 1'b0;
  logic [31:0]   pc_in = '0;
  logic [31:0]   result_in = '0;
  logic          freeze = 1'b0;
  logic          prev = 1'b0;
  logic          next = 1'b0;
  logic          sclr = 1'b0;
  logic [31:0]   pc_out;
  logic [31:0]   result_out;
  logic [AW:0]   count;
  logic [AW-1:0] offset;
  logic          wrapped;
  logic [7:0]    dropped;

  always #5 clk = ~clk;

  trace_capture #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .retire     (retire),
    .pc_in      (pc_in),
    .result_in  (result_in),
    .freeze     (freeze),
    .prev       (prev),
    .next       (next),
    .sclr       (sclr),
    .pc_out     (pc_out),
    .result_out (result_out),
    .count      (count),
    .offset     (offset),
    .wrapped    (wrapped),
    .dropped    (dropped)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] hist[$];
  int          m_off;
  bit          m_wrap;
  int          m_drop;
  logic [63:0] dq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_data();
    if (hist.size() == 0) return 64'h0;
    return hist[m_off];
  endfunction

  task automatic model_clear();
    hist.delete();
    m_off  = 0;
    m_wrap = 0;
    m_drop = 0;
  endtask

  task automatic step(input bit r, input logic [31:0] pc, input logic [31:0] res,
                      input bit fr, input bit p, input bit n, input bit s);
    logic [63:0] d;
    retire = r; pc_in = pc; result_in = res; freeze = fr; prev = p; next = n; sclr = s;
    if (s) begin
      model_clear();
      // pc_out is cleared on the sclr edge itself
      dq.delete();
      dq.push_back(64'h0);
    end else if (r && !fr) begin
      hist.push_front({pc, res});
      if (hist.size() > DEPTH) begin
        void'(hist.pop_back());
        m_wrap = 1;
      end
      m_off = 0;
    end else begin
      if (r && m_drop != 255) m_drop++;
      if (p && !n) begin
        if (m_off + 1 < hist.size()) m_off++;
      end else if (n && !p) begin
        if (m_off > 0) m_off--;
      end
    end
    dq.push_back(exp_data());
    @(posedge clk);
    #1;
    retire = 0; prev = 0; next = 0; sclr = 0;
    chk("count", 64'(count), 64'(hist.size()));
    chk("offset", 64'(offset), 64'(m_off));
    chk("wrapped", 64'(wrapped), 64'(m_wrap));
    chk("dropped", 64'(dropped), 64'(m_drop));
    if (dq.size() >= 2) begin
      d = dq.pop_front();
      chk("pc_out", 64'(pc_out), 64'(d[63:32]));
      chk("result_out", 64'(result_out), 64'(d[31:0]));
    end
  endtask

  task automatic idle(input bit fr);
    step(1'b0, 32'h0, 32'h0, fr, 1'b0, 1'b0, 1'b0);
  endtask

  // Asserts rst_n wherever the bench currently is (between edges) and checks
  // that every output clears without waiting for a clock.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    retire = 0; prev = 0; next = 0; sclr = 0; freeze = 0;
    #1;
    chk({tag, "_count"}, 64'(count), 64'h0);
    chk({tag, "_offset"}, 64'(offset), 64'h0);
    chk({tag, "_wrapped"}, 64'(wrapped), 64'h0);
    chk({tag, "_dropped"}, 64'(dropped), 64'h0);
    chk({tag, "_pc"}, 64'(pc_out), 64'h0);
    chk({tag, "_res"}, 64'(result_out), 64'h0);
    model_clear();
    dq.delete();
    dq.push_back(64'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #3;
    do_reset("rst");

    // three retires, live view of the newest
    step(1, 32'h00, 32'h11, 0, 0, 0, 0);
    step(1, 32'h04, 32'h22, 0, 0, 0, 0);
    step(1, 32'h08, 32'h33, 0, 0, 0, 0);
    idle(0);
    chk("t1_count", 64'(count), 64'd3);
    chk("t1_offset", 64'(offset), 64'd0);
    chk("t1_pc", 64'(pc_out), 64'h08);
    chk("t1_res", 64'(result_out), 64'h33);
    chk("t1_wrapped", 64'(wrapped), 64'd0);

    // browse back to the oldest, bump the limit, then step forward
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    idle(1);
    chk("t2_offset", 64'(offset), 64'd2);
    chk("t2_pc", 64'(pc_out), 64'h00);
    step(0, 0, 0, 1, 1, 0, 0);
    idle(1);
    chk("t2_limit", 64'(offset), 64'd2);
    step(0, 0, 0, 1, 0, 1, 0);
    idle(1);
    chk("t2_next_off", 64'(offset), 64'd1);
    chk("t2_next_pc", 64'(pc_out), 64'h04);

    // overflow the ring; oldest survivor is the third of ten
    for (int k = 0; k < 10; k++) step(1, 32'h100 + 32'(4 * k), 32'hA000 + 32'(k), 0, 0, 0, 0);
    idle(0);
    chk("t3_count", 64'(count), 64'd8);
    chk("t3_wrapped", 64'(wrapped), 64'd1);
    chk("t3_pc_live", 64'(pc_out), 64'h124);
    for (int k = 0; k < 7; k++) step(0, 0, 0, 1, 1, 0, 0);
    idle(1);
    chk("t3_offset", 64'(offset), 64'd7);
    chk("t3_oldest", 64'(pc_out), 64'h108);
    step(0, 0, 0, 1, 1, 0, 0);
    idle(1);
    chk("t3_limit", 64'(offset), 64'd7);
    chk("t3_oldest2", 64'(pc_out), 64'h108);

    // frozen retires are dropped and counted with saturation
    for (int k = 0; k < 300; k++) step(1, $urandom, $urandom, 1, 0, 0, 0);
    idle(1);
    chk("t4_dropped", 64'(dropped), 64'hFF);
    chk("t4_pc", 64'(pc_out), 64'h108);
    chk("t4_count", 64'(count), 64'd8);

    // capture beats browse in the same cycle
    step(1, 32'h200, 32'h55, 0, 1, 1, 0);
    idle(0);
    chk("t5_offset", 64'(offset), 64'd0);
    chk("t5_pc", 64'(pc_out), 64'h200);

    // prev and next together cancel
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    idle(0);
    chk("t6_offset", 64'(offset), 64'd1);

    // sclr mid-history with count=5, offset=3, dropped nonzero
    step(0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) step(1, 32'h300 + 32'(4 * k), 32'hB0 + 32'(k), 0, 0, 0, 0);
    step(1, 32'hDEAD, 32'hBEEF, 1, 1, 0, 0);
    step(1, 32'hDEAD, 32'hBEEF, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    idle(1);
    chk("t7_pre_count", 64'(count), 64'd5);
    chk("t7_pre_offset", 64'(offset), 64'd3);
    chk("t7_pre_pc", 64'(pc_out), 64'h304);
    step(0, 0, 0, 1, 0, 0, 1);
    chk("t7_count", 64'(count), 64'd0);
    chk("t7_offset", 64'(offset), 64'd0);
    chk("t7_dropped", 64'(dropped), 64'd0);
    chk("t7_pc", 64'(pc_out), 64'h0);
    chk("t7_res", 64'(result_out), 64'h0);

    // random mix against the model
    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0));

    // build wrapped/dropped state, then async reset between edges
    for (int k = 0; k < 10; k++) step(1, 32'h400 + 32'(k), 32'(k), 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0);
    #2;
    do_reset("arst");
    step(1, 32'h500, 32'h66, 0, 0, 0, 0);
    idle(0);
    chk("t8_pc", 64'(pc_out), 64'h500);
    chk("t8_count", 64'(count), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
